dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 14, meaning word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data width (byte-enable width DATA_W/8).
REQ-003 The block SHALL have parameter MAX_LOCK, default 16, meaning maximum consecutive loader-locked grants.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 c_req_valid / c_req_ready  input/output  1  core request handshake.
REQ-007 c_addr  input  ADDR_W; c_we  input  4 (byte enables, 0 = read); c_wdata  input  DATA_W.
REQ-008 c_rvalid  output  1; c_rdata  output  DATA_W  core read response.
REQ-009 l_req_valid, l_req_ready, l_addr, l_we, l_wdata, l_rvalid, l_rdata  same widths  loader port (UART bootloader).
REQ-010 l_lock  input  1  loader requests ownership retention.
REQ-011 mem_en  output  1; mem_we  output  4; mem_addr  output  ADDR_W; mem_wdata  output  DATA_W; mem_rdata  input  DATA_W (sync RAM, 1-cycle read latency).

Function
REQ-012 At most one request SHALL be granted per cycle; a grant occurs when the chosen port's valid and ready are both high.
REQ-013 Ready SHALL be combinational from valid and arbiter state; the winner's addr/we/wdata SHALL drive mem_* in the same cycle with mem_en=1, else mem_en=0, mem_we=0.
REQ-014 Arbitration SHALL be round-robin: when both ports are valid, grant the port not granted last; rr pointer updates only on a grant.
REQ-015 FSM states: IDLE, OPEN, LDR_LOCK.
REQ-016 IDLE->OPEN one cycle after reset release; no grants in IDLE.
REQ-017 OPEN->LDR_LOCK on a loader grant with l_lock=1; lock counter loads 1.
REQ-018 In LDR_LOCK: c_req_ready=0; a loader grant increments the counter.
REQ-019 LDR_LOCK->OPEN when l_lock=0, or when the counter reaches MAX_LOCK and c_req_valid=1.
REQ-020 On forced exit, the rr pointer SHALL favour the core, so the core wins the next cycle.
REQ-021 Counter saturates at MAX_LOCK and does not wrap.
REQ-022 A read grant (we=0) SHALL assert the owner's rvalid exactly one cycle later for one cycle, with rdata=mem_rdata; the other port's rvalid=0.
REQ-023 Writes SHALL produce no rvalid.
REQ-024 Back-to-back reads SHALL yield one rvalid per cycle, tagged by a registered owner bit.
REQ-025 Invalid ports SHALL never be granted; ready for an invalid port SHALL be 0.

Reset
REQ-026 On rst_n=0, all of the following SHALL clear asynchronously: state=IDLE, rr pointer=core, lock counter=0, pending-read tag invalid, all ready/rvalid/mem_en/mem_we=0.
REQ-027 A read granted in the cycle before reset assertion SHALL NOT produce rvalid after release.

Structure
REQ-028 The FSM state encoding, and the port-ID constants CORE=0 and LDR=1, SHALL live in the shared CPU package.
REQ-029 One sub-module, rr_arb2 (2-way round-robin grant with pointer), is natural; the FSM and response tagging stay top level.

Verification
REQ-030 Core-only read at addr 0x0005, RAM word 0x1122_3344 -> c_req_ready same cycle; c_rvalid next cycle with c_rdata=0x1122_3344; l_rvalid=0.
REQ-031 Both ports valid for 4 cycles, rr at reset -> grants C,L,C,L.
REQ-032 Loader writes with l_lock=1 and core valid throughout, MAX_LOCK=16 -> 16 loader grants, then core granted on the 17th, then alternation.
REQ-033 Loader sb-style write to addr 9, l_we=4'b1000, l_wdata=0xaabb_ccdd -> mem_we=4'b1000, mem_addr=9; no rvalid.
REQ-034 rst_n pulsed low one cycle after a core read grant -> no c_rvalid after release; first grant occurs ≥2 cycles after release.
REQ-035 l_lock dropped after 3 locked grants, core valid -> FSM returns to OPEN; core granted the next cycle.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_pkg
// Brief    : Shared CPU types: data-memory arbiter FSM encoding and port IDs.
// Revision : 1.0
// ============================================================================
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_OPEN     = 2'd1,
    ST_LDR_LOCK = 2'd2
  } arb_state_t;

  // Port IDs double as bit indices into request/grant vectors.
  localparam logic CORE = 1'b0;
  localparam logic LDR  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-way round-robin grant; the pointer names the port that wins a tie.
// Revision : 1.0
// ============================================================================
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       force_core,
  output logic [1:0] gnt
);

  logic r_ptr;

  always_comb begin
    gnt = 2'b00;
    if (req[CORE] && (!req[LDR] || (r_ptr == CORE))) begin
      gnt[CORE] = 1'b1;
    end else if (req[LDR]) begin
      gnt[LDR] = 1'b1;
    end
  end

  // The port just served yields the tie-break; a forced lock exit hands it to the core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= CORE;
    end else if (force_core) begin
      r_ptr <= CORE;
    end else if (gnt[CORE]) begin
      r_ptr <= LDR;
    end else if (gnt[LDR]) begin
      r_ptr <= CORE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Core / bootloader arbiter in front of a 1-cycle-latency data RAM.
// Revision : 1.0
// ============================================================================
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                c_req_valid,
  output logic                c_req_ready,
  input  logic [ADDR_W-1:0]   c_addr,
  input  logic [DATA_W/8-1:0] c_we,
  input  logic [DATA_W-1:0]   c_wdata,
  output logic                c_rvalid,
  output logic [DATA_W-1:0]   c_rdata,
  input  logic                l_req_valid,
  output logic                l_req_ready,
  input  logic [ADDR_W-1:0]   l_addr,
  input  logic [DATA_W/8-1:0] l_we,
  input  logic [DATA_W-1:0]   l_wdata,
  output logic                l_rvalid,
  output logic [DATA_W-1:0]   l_rdata,
  input  logic                l_lock,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] c_lock_max = CNT_W'(MAX_LOCK);

  arb_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_lock_cnt, w_lock_cnt_nxt;
  logic [1:0]       w_req, w_gnt;
  logic             w_force_core;
  logic             r_rd_pend, r_rd_owner;

  // The core is masked out entirely while the loader holds the lock.
  always_comb begin
    w_req = 2'b00;
    if (r_state == ST_OPEN) begin
      w_req = {l_req_valid, c_req_valid};
    end else if (r_state == ST_LDR_LOCK) begin
      w_req = {l_req_valid, 1'b0};
    end
  end

  rr_arb2 u_rr_arb2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (w_req),
    .force_core (w_force_core),
    .gnt        (w_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    w_force_core   = 1'b0;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_OPEN;
      ST_OPEN: begin
        if (w_gnt[LDR] && l_lock) begin
          w_state_nxt    = ST_LDR_LOCK;
          w_lock_cnt_nxt = CNT_W'(1);
        end
      end
      ST_LDR_LOCK: begin
        if (w_gnt[LDR] && (r_lock_cnt != c_lock_max)) begin
          w_lock_cnt_nxt = r_lock_cnt + 1'b1;
        end
        // Exit is judged on the post-grant count so the core is served right after the last locked grant.
        if (!l_lock) begin
          w_state_nxt = ST_OPEN;
        end else if ((w_lock_cnt_nxt == c_lock_max) && c_req_valid) begin
          w_state_nxt  = ST_OPEN;
          w_force_core = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign c_req_ready = w_gnt[CORE];
  assign l_req_ready = w_gnt[LDR];
  assign mem_en      = |w_gnt;

  always_comb begin
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_gnt[CORE]) begin
      mem_we    = c_we;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
    end else if (w_gnt[LDR]) begin
      mem_we    = l_we;
      mem_addr  = l_addr;
      mem_wdata = l_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend  <= 1'b0;
      r_rd_owner <= CORE;
    end else begin
      r_rd_pend <= mem_en && (mem_we == '0);
      if (mem_en) begin
        r_rd_owner <= w_gnt[LDR] ? LDR : CORE;
      end
    end
  end

  assign c_rvalid = r_rd_pend && (r_rd_owner == CORE);
  assign l_rvalid = r_rd_pend && (r_rd_owner == LDR);
  assign c_rdata  = mem_rdata;
  assign l_rdata  = mem_rdata;

endmodule
`default_nettype wire
